// File: rtl/bk_sd_xfer.sv
// bk_sd_xfer: backup RAM transfer engine between one SD virtual disk
// and the SDRAM port, staged through a 256x16 sector buffer.
module bk_sd_xfer #(
  parameter logic [24:0] BASE_A      = 25'h0,
  parameter int          MAX_SECTORS = 256
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        img_mounted,
  input  logic [63:0] img_size,
  output logic        bk_ena,
  input  logic        bk_load,
  input  logic        bk_save,
  output logic        bk_loading,
  output logic        bk_saving,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic [7:0]  sd_buff_addr,
  input  logic [15:0] sd_buff_dout,
  input  logic        sd_buff_wr,
  output logic [15:0] sd_buff_din,
  output logic        mem_req,
  output logic        mem_we,
  output logic [24:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [2:0] {
    IDLE,
    LD_REQ,
    LD_RECV,
    LD_DRAIN,
    SV_FILL,
    SV_REQ,
    SV_SEND
  } state_t;

  localparam logic [63:0] MAX_Q = 64'(MAX_SECTORS);

  state_t      state;
  state_t      state_nx;
  logic [31:0] nsec;
  logic [31:0] cnt;
  logic [31:0] sec;
  logic [7:0]  word;
  logic        rdy;
  logic [63:0] size_q;
  logic        last_ack;
  logic        sec_done;
  logic [24:0] xfer_addr;

  logic [15:0] sbuf [256];
  logic [15:0] sbuf_q;
  logic        sbuf_we;
  logic [7:0]  sbuf_wa;
  logic [15:0] sbuf_wd;
  logic [7:0]  sbuf_ra;

  assign size_q    = {9'd0, img_size[63:9]} + {63'd0, |img_size[8:0]};
  assign last_ack  = mem_req && mem_ack && (word == 8'hFF);
  assign sec_done  = (sec + 32'd1) == cnt;
  assign xfer_addr = BASE_A + {sec[15:0], word, 1'b0};
  assign sd_lba    = sec;
  assign sd_buff_din = sbuf_q;

  assign sbuf_we = (state == LD_RECV && sd_buff_wr) ||
                   (state == SV_FILL && mem_req && mem_ack);
  assign sbuf_wa = (state == LD_RECV) ? sd_buff_addr : word;
  assign sbuf_wd = (state == LD_RECV) ? sd_buff_dout : mem_rdata;
  assign sbuf_ra = (state == LD_DRAIN) ? word : sd_buff_addr;

  // FSM state register
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // next state, SD requests and busy flags
  always_comb begin
    state_nx   = state;
    sd_rd      = 1'b0;
    sd_wr      = 1'b0;
    bk_loading = 1'b0;
    bk_saving  = 1'b0;
    case (state)
      IDLE: begin
        if (bk_load && bk_ena)      state_nx = LD_REQ;
        else if (bk_save && bk_ena) state_nx = SV_FILL;
      end
      LD_REQ: begin
        sd_rd      = 1'b1;
        bk_loading = 1'b1;
        if (sd_ack) state_nx = LD_RECV;
      end
      LD_RECV: begin
        bk_loading = 1'b1;
        if (!sd_ack) state_nx = LD_DRAIN;
      end
      LD_DRAIN: begin
        bk_loading = 1'b1;
        if (last_ack) state_nx = sec_done ? IDLE : LD_REQ;
      end
      SV_FILL: begin
        bk_saving = 1'b1;
        if (last_ack) state_nx = SV_REQ;
      end
      SV_REQ: begin
        sd_wr     = 1'b1;
        bk_saving = 1'b1;
        if (sd_ack) state_nx = SV_SEND;
      end
      SV_SEND: begin
        bk_saving = 1'b1;
        if (!sd_ack) state_nx = sec_done ? IDLE : SV_FILL;
      end
      default: state_nx = IDLE;
    endcase
  end

  // size register, sector/word counters and the SDRAM request
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      nsec      <= '0;
      bk_ena    <= 1'b0;
      cnt       <= '0;
      sec       <= '0;
      word      <= '0;
      rdy       <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if (img_mounted) begin
        nsec   <= (size_q > MAX_Q) ? MAX_Q[31:0] : size_q[31:0];
        bk_ena <= |img_size;
      end
      case (state)
        IDLE: begin
          if (state_nx != IDLE) begin
            sec  <= '0;
            cnt  <= nsec;
            word <= '0;
            rdy  <= 1'b0;
          end
        end
        LD_RECV: begin
          word <= '0;
          rdy  <= 1'b0;
        end
        LD_DRAIN: begin
          if (mem_req) begin
            if (mem_ack) begin
              mem_req <= 1'b0;
              word    <= word + 8'd1;
              if (word == 8'hFF) sec <= sec + 32'd1;
            end
          end else if (rdy) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= xfer_addr;
            mem_wdata <= sbuf_q;
            rdy       <= 1'b0;
          end else begin
            rdy <= 1'b1;
          end
        end
        SV_FILL: begin
          if (mem_req) begin
            if (mem_ack) begin
              mem_req <= 1'b0;
              word    <= word + 8'd1;
            end
          end else begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= xfer_addr;
          end
        end
        SV_SEND: begin
          if (!sd_ack) begin
            sec  <= sec + 32'd1;
            word <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // sector buffer write port
  always_ff @(posedge clk_sys) begin
    if (sbuf_we) sbuf[sbuf_wa] <= sbuf_wd;
  end

  // sector buffer registered read port
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) sbuf_q <= '0;
    else       sbuf_q <= sbuf[sbuf_ra];
  end

endmodule

// File: doc/bk_sd_xfer.md
Name: bk_sd_xfer

Overview:
- Backup-RAM transfer engine between the MiSTer SD block interface (one virtual disk) and the SDRAM memory port.
- On bk_load it streams the mounted image sector by sector into SDRAM at BASE_A. On bk_save it streams SDRAM back out to the image.
- Holds one internal 256x16 sector buffer. pcfx_top instantiates one copy per volume: SRAM and BMP.

Parameters:
- BASE_A, 25'h0, SDRAM byte base address of the backing region
- MAX_SECTORS, 256, maximum sectors transferred; the image is clamped to this

Ports:
- clk_sys  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- img_mounted  in  1  one-cycle pulse: new image mounted
- img_size  in  64  image size in bytes, valid with img_mounted
- bk_ena  out  1  a non-empty image is mounted
- bk_load  in  1  level request: image -> SDRAM
- bk_save  in  1  level request: SDRAM -> image
- bk_loading  out  1  load in progress
- bk_saving  out  1  save in progress
- sd_lba  out  32  sector number, stable while sd_rd/sd_wr/sd_ack are high
- sd_rd  out  1  sector read request
- sd_wr  out  1  sector write request
- sd_ack  in  1  host busy with the current sector
- sd_buff_addr  in  8  host word index
- sd_buff_dout  in  16  host -> block data
- sd_buff_wr  in  1  strobe: write sd_buff_dout to buf[sd_buff_addr]
- sd_buff_din  out  16  block -> host data, buf[sd_buff_addr]
- mem_req  out  1  SDRAM request, held until mem_ack
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  25  SDRAM byte address
- mem_wdata  out  16  write data
- mem_rdata  in  16  read data, valid with mem_ack
- mem_ack  in  1  one-cycle completion pulse

Behaviour:
- Reset values: every output 0, FSM in IDLE, size register 0.
- Size register
  - On img_mounted: nsec = ceil(img_size/512), clamped to MAX_SECTORS; bk_ena = (img_size != 0).
  - Updates in any state. An active transfer uses the count it latched at start.
- FSM states: IDLE, LD_REQ, LD_RECV, LD_DRAIN, SV_FILL, SV_REQ, SV_SEND.
- IDLE
  - bk_load & bk_ena -> LD_REQ, sec=0.
  - Otherwise bk_save & bk_ena -> SV_FILL, sec=0.
  - Load wins if both are asserted in the same cycle. Requests with bk_ena=0 are ignored.
  - The request levels are sampled only in IDLE.
- Load path
  - LD_REQ: sd_lba=sec, sd_rd=1. On sd_ack rise: sd_rd=0 in the next cycle -> LD_RECV.
  - LD_RECV: sd_buff_wr writes the buffer. On sd_ack fall -> LD_DRAIN, word=0.
  - LD_DRAIN: issue 256 writes, mem_addr = BASE_A + sec*512 + word*2, mem_wdata = buf[word]. Each write advances on mem_ack.
  - After word 255: sec+1; if sec+1 == nsec -> IDLE, else LD_REQ.
- Save path
  - SV_FILL: 256 reads at the same addresses, mem_rdata written to buf[word] on mem_ack. Then -> SV_REQ.
  - SV_REQ: sd_wr=1, sd_lba=sec. On sd_ack rise: sd_wr=0 -> SV_SEND.
  - SV_SEND: sd_buff_din = buf[sd_buff_addr], registered, valid 1 cycle after the address changes. On sd_ack fall: sec+1; if done -> IDLE, else SV_FILL.
- Status flags: bk_loading is high in the LD_* states and bk_saving in the SV_* states. Both deassert in the cycle the FSM enters IDLE.
- Buffer access ports: sd_buff_wr is accepted only in LD_RECV and ignored elsewhere. A single write port and a single read port suffice.
- Address arithmetic: 25-bit, wraps modulo 2^25 with no error.
- Handshake rules
  - mem_req deasserts the cycle after mem_ack; at most one request is outstanding.
  - mem_addr, mem_we and mem_wdata stay stable while mem_req=1.
- Reset mid-operation: immediate return to IDLE with all outputs 0. SDRAM contents already written are left as-is.

Test Plan:
- Mount img_size=1024, then bk_load pulse. Expect:
  - sd_rd for lba 0, then lba 1.
  - 512 SDRAM writes at BASE_A..BASE_A+0x3FE matching the file words.
  - bk_loading falls after the last mem_ack; bk_ena=1 throughout.
- Preload SDRAM with word pattern i^0xA5A5 (i = word index), mount size=512, pulse bk_save. Expect:
  - 256 reads, then sd_wr with lba 0.
  - The written file equals the pattern; bk_saving high until sd_ack falls.
- img_size=0 mount, then bk_load: bk_ena=0, no sd_rd and no mem_req for 1000 cycles.
- Size and clamp edge cases:
  - img_size=700: exactly 2 sectors loaded.
  - MAX_SECTORS=4 with img_size=8192: 4 sectors, last lba=3.
- bk_load and bk_save asserted in the same cycle: load performed, no sd_wr issued. A later bk_save alone performs the save.
- Reset asserted during LD_DRAIN at word 100: all outputs 0 asynchronously. A subsequent bk_load restarts at lba 0.
